// File: rtl/dmem_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, lane width, FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// plus load lane extraction with sign/zero extension. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_we,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [LANE_W-1:0]   rbyte;
  logic [2*LANE_W-1:0] rhalf;

  always_comb begin
    rbyte       = rword[{addr_lo, 3'b000} +: LANE_W];
    rhalf       = addr_lo[1] ? rword[31:16] : rword[15:0];
    lane_we     = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = rword;
    // Replicating the sub-word data lets the lane enables alone pick the target lane.
    case (size)
      SZ_BYTE: begin
        lane_we     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        lane_we     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      default: begin
        lane_we     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_subword.sv
// Byte/half/word data memory with valid/ready handshake and READ_LAT busy cycles.
// Define DMEM_ERR_CHECK_EN to enable size/alignment/range error reporting on resp_err.
module data_memory_subword
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h7FFFFC00,
  parameter int          READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_ERR_CHECK_EN
  localparam int AQ_W = 32;
`else
  localparam int AQ_W = IDX_W + 2;
`endif
  localparam int OFF_W = AQ_W - 2;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [AQ_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [LANE_W-1:0] mem [4][DEPTH];

  logic [OFF_W-1:0]  off_w;
  logic [IDX_W-1:0]  idx;
  logic              acc_err;
  logic              commit;
  logic [31:0]       rword;
  logic [3:0]        lane_we;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rdata_ext;

  // Word offset from the base; below-base addresses wrap to huge offsets and fail the range test.
  assign off_w = addr_q[AQ_W-1:2] - BASE_ADDR[AQ_W-1:2];
  assign idx   = off_w[IDX_W-1:0];

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = (size_q == 2'b11)
                || ((size_q == SZ_HALF) && addr_q[0])
                || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                || (|off_w[OFF_W-1:IDX_W]);
`else
  assign acc_err = 1'b0;
`endif

  assign rword  = {mem[3][idx], mem[2][idx], mem[1][idx], mem[0][idx]};
  assign commit = (state_q == BUSY) && (cnt_q == 2'd0);

  dmem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (rword),
    .lane_we     (lane_we),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr[AQ_W-1:0];
          wdata_d    = req_wdata;
          cnt_d      = 2'(READ_LAT - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          rdata_d = (write_q || acc_err) ? 32'd0 : rdata_ext;
          err_d   = acc_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      write_q    <= 1'b0;
      size_q     <= SZ_WORD;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Contents are not reset; a reset drops the FSM out of BUSY so no commit follows it.
  always_ff @(posedge clk) begin
    if (commit && write_q && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) mem[k][idx] <= wdata_lanes[k*LANE_W +: LANE_W];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_subword.sv
// Directed bench for data_memory_subword: one instance with READ_LAT=1, one with READ_LAT=3.
module tb_data_memory_subword;

  logic        clk;
  logic        reset;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];

  int total = 0;
  int bad   = 0;
  int lat_of [2] = '{1, 3};

  data_memory_subword #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_memory_subword #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic wr, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd, logic er);
    vec_t v;
    v.name = n; v.wr = wr; v.sz = sz; v.uns = uns;
    v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic access(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = wr; req_size[u] = sz; req_unsigned[u] = uns;
    req_addr[u] = a; req_wdata[u] = wd; resp_ready[u] = 1'b0;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    lat = 0;
    while (resp_valid[u] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata[u];
    er = resp_err[u];
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_size[u] = 2'b10; req_unsigned[u] = 1'b0;
      req_addr[u] = 32'd0; req_wdata[u] = 32'd0; resp_ready[u] = 1'b0;
    end

    // Word / byte-merge / extension / half / boundary vectors, shared by both instances
    add("st_w_c10",   1, 2'b10, 0, 32'h7FFFFC10, 32'hDEADBEEF, 32'h0,        0);
    add("ld_w_c10",   0, 2'b10, 0, 32'h7FFFFC10, 32'h0,        32'hDEADBEEF, 0);
    add("st_w_c20",   1, 2'b10, 0, 32'h7FFFFC20, 32'h11223344, 32'h0,        0);
    add("st_b_c22",   1, 2'b00, 0, 32'h7FFFFC22, 32'h000000AA, 32'h0,        0);
    add("ld_w_c20",   0, 2'b10, 0, 32'h7FFFFC20, 32'h0,        32'h11AA3344, 0);
    add("st_w_c30",   1, 2'b10, 0, 32'h7FFFFC30, 32'h80FF7F01, 32'h0,        0);
    add("ld_bs_c32",  0, 2'b00, 0, 32'h7FFFFC32, 32'h0,        32'hFFFFFFFF, 0);
    add("ld_bu_c32",  0, 2'b00, 1, 32'h7FFFFC32, 32'h0,        32'h000000FF, 0);
    add("ld_hs_c32",  0, 2'b01, 0, 32'h7FFFFC32, 32'h0,        32'hFFFF80FF, 0);
    add("ld_hu_c30",  0, 2'b01, 1, 32'h7FFFFC30, 32'h0,        32'h00007F01, 0);
    add("ld_bs_c31",  0, 2'b00, 0, 32'h7FFFFC31, 32'h0,        32'h0000007F, 0);
    add("ld_wu_c30",  0, 2'b10, 1, 32'h7FFFFC30, 32'h0,        32'h80FF7F01, 0);
    add("st_h_c12",   1, 2'b01, 0, 32'h7FFFFC12, 32'h1234CAFE, 32'h0,        0);
    add("ld_w_c10b",  0, 2'b10, 0, 32'h7FFFFC10, 32'h0,        32'hCAFEBEEF, 0);
    add("st_b_c13",   1, 2'b00, 0, 32'h7FFFFC13, 32'h00000055, 32'h0,        0);
    add("ld_bu_c13",  0, 2'b00, 1, 32'h7FFFFC13, 32'h0,        32'h00000055, 0);
    add("st_w_top",   1, 2'b10, 0, 32'h7FFFFFFC, 32'hA5A50001, 32'h0,        0);
    add("ld_w_top",   0, 2'b10, 0, 32'h7FFFFFFC, 32'h0,        32'hA5A50001, 0);
    add("st_w_c40",   1, 2'b10, 0, 32'h7FFFFC40, 32'h00000005, 32'h0,        0);
    add("st_w_c00",   1, 2'b10, 0, 32'h7FFFFC00, 32'h600D600D, 32'h0,        0);
`ifdef DMEM_ERR_CHECK_EN
    add("err_st_c41", 1, 2'b10, 0, 32'h7FFFFC41, 32'h00000077, 32'h0,        1);
    add("ld_w_c40",   0, 2'b10, 0, 32'h7FFFFC40, 32'h0,        32'h00000005, 0);
    add("err_ld_c41", 0, 2'b10, 0, 32'h7FFFFC41, 32'h0,        32'h0,        1);
    add("err_ld_h31", 0, 2'b01, 0, 32'h7FFFFC31, 32'h0,        32'h0,        1);
    add("err_sz11",   0, 2'b11, 0, 32'h7FFFFC40, 32'h0,        32'h0,        1);
    add("err_st_1000",1, 2'b10, 0, 32'h00001000, 32'h0BADF00D, 32'h0,        1);
    add("err_ld_1000",0, 2'b10, 0, 32'h00001000, 32'h0,        32'h0,        1);
    add("ld_w_c00",   0, 2'b10, 0, 32'h7FFFFC00, 32'h0,        32'h600D600D, 0);
`else
    add("ld_w_c41",   0, 2'b10, 0, 32'h7FFFFC41, 32'h0,        32'h00000005, 0);
    add("ld_sz11",    0, 2'b11, 0, 32'h7FFFFC40, 32'h0,        32'h00000005, 0);
    add("ld_h_c31",   0, 2'b01, 1, 32'h7FFFFC31, 32'h0,        32'h00007F01, 0);
    add("st_w_1000",  1, 2'b10, 0, 32'h00001000, 32'h0BADF00D, 32'h0,        0);
    add("ld_w_c00",   0, 2'b10, 0, 32'h7FFFFC00, 32'h0,        32'h0BADF00D, 0);
`endif

    // Reset state
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_req_ready%0d", u), 32'(req_ready[u]), 32'd1);
      chk($sformatf("rst_resp_valid%0d", u), 32'(resp_valid[u]), 32'd0);
      chk($sformatf("rst_rdata%0d", u), resp_rdata[u], 32'd0);
      chk($sformatf("rst_err%0d", u), 32'(resp_err[u]), 32'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int u = 0; u < 2; u++) begin
      foreach (vecs[i]) begin
        access(u, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
        chk($sformatf("%s_u%0d_rdata", vecs[i].name, u), rd, vecs[i].exp_rd);
        chk($sformatf("%s_u%0d_err", vecs[i].name, u), 32'(er), 32'(vecs[i].exp_err));
        chk($sformatf("%s_u%0d_lat", vecs[i].name, u), 32'(lat), 32'(lat_of[u]));
      end
    end

    // Backpressure on READ_LAT=3; a store offered during RESP must not be taken
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h7FFFFC10; resp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (resp_valid[1] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd3);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_wdata[1] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(resp_valid[1]), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), resp_rdata[1], 32'h55FEBEEF);
      chk($sformatf("bp_err_c%0d", c), 32'(resp_err[1]), 32'd0);
      chk($sformatf("bp_req_ready_c%0d", c), 32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    req_valid[1] = 1'b0;
    chk("bp_idle_req_ready", 32'(req_ready[1]), 32'd1);
    chk("bp_idle_resp_valid", 32'(resp_valid[1]), 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFC10, 32'h0, rd, er, lat);
    chk("bp_no_store", rd, 32'h55FEBEEF);

    // Reset during BUSY on READ_LAT=3: the store to 0x7FFFFC40 must be dropped
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'b10;
    req_addr[1] = 32'h7FFFFC40; req_wdata[1] = 32'h9;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("busy_req_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rbusy_req_ready", 32'(req_ready[1]), 32'd1);
    chk("rbusy_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("rbusy_rdata", resp_rdata[1], 32'd0);
    chk("rbusy_err", 32'(resp_err[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    access(1, 1'b0, 2'b10, 1'b0, 32'h7FFFFC40, 32'h0, rd, er, lat);
    chk("rbusy_ld_c40", rd, 32'h5);
    chk("rbusy_ld_lat", 32'(lat), 32'd3);

    // Reset during RESP on READ_LAT=1: response dropped, memory kept
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'b10;
    req_addr[0] = 32'h7FFFFC20; resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rresp_pre_rdata", resp_rdata[0], 32'h11AA3344);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rresp_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rresp_rdata", resp_rdata[0], 32'd0);
    chk("rresp_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    access(0, 1'b0, 2'b10, 1'b0, 32'h7FFFFC40, 32'h0, rd, er, lat);
    chk("rresp_ld_c40", rd, 32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
